crf_lite_master: RTL and testbench
==================================

// Module: crf_lite_master
// PURPOSE
//  AXI4-Lite master that drives the config register file from the bus side: writes UPSTART, waits for UPEND, reads UPINHSKCNT.
//  Sits in the verification env / SoC shell opposite the CRF lite slave; a host pulse on start runs one full upscale job.
//  Reports completion, handshake count and bus errors to the host.
// PARAMETERS
//  AXI_DATA_WIDTH  32          lite data width (>=32)
//  AXI_ADDR_WIDTH  32          lite address width
//  UPSTART_ADDR    'h0         byte address of UPSTART register
//  UPEND_ADDR      'h4         byte address of UPEND register (bit0 = job done)
//  UPINHSKCNT_ADDR 'h8         byte address of input handshake count register
//  POLL_GAP        16          idle cycles between UPEND polls (>=1)
//  TIMEOUT         2**20       max cycles from start to UPEND seen; 0 disables
// PORTS
//  clk             in   1      clock
//  rst             in   1      synchronous, active-high reset
//  start           in   1      1-cycle pulse: begin job; ignored unless idle
//  busy            out  1      job in progress
//  done            out  1      1-cycle pulse: job finished OK
//  error           out  1      sticky; cleared by next accepted start
//  err_code        out  2      0 none, 1 BRESP!=OKAY, 2 RRESP!=OKAY, 3 timeout
//  hskcnt          out  AXI_DATA_WIDTH  UPINHSKCNT value, valid from done
//  m_axi_aw{valid,addr,prot} out 1/AXI_ADDR_WIDTH/3 ; m_axi_awready in 1
//  m_axi_w{valid,data,strb}  out 1/AXI_DATA_WIDTH/AXI_DATA_WIDTH/8 ; m_axi_wready in 1
//  m_axi_b{valid,resp} in 1/2 ; m_axi_bready out 1
//  m_axi_ar{valid,addr,prot} out 1/AXI_ADDR_WIDTH/3 ; m_axi_arready in 1
//  m_axi_r{valid,data,resp}  in 1/AXI_DATA_WIDTH/2 ; m_axi_rready out 1
//  interrupt_updone in  1      CRF done interrupt (used only with macro)
// BEHAVIOUR
//  Reset: all outputs 0 (valids, readies, busy, done, error, err_code, hskcnt, addr/data); FSM -> IDLE; counters 0.
//  States: IDLE, WR, WR_RESP, GAP, RD_END, RD_CNT, FIN, ERR.
//  IDLE: start -> WR, busy=1, error/err_code cleared, timeout counter cleared.
//  WR: awvalid and wvalid asserted same cycle, awaddr=UPSTART_ADDR, wdata=1, wstrb=all-ones, prot=0.
//   Each valid drops independently the cycle after its own ready handshake; never deasserts before handshake.
//   Both accepted -> WR_RESP with bready=1 (AW/W accepted same cycle: transition next cycle).
//  WR_RESP: bvalid&bready -> bresp==OKAY ? GAP : ERR(code 1). bready drops on handshake.
//  GAP: count POLL_GAP cycles -> RD_END (arvalid=1, araddr=UPEND_ADDR).
//  RD_END: arvalid held to arready; then rready=1; on rvalid: rresp!=OKAY -> ERR(2); rdata[0] ? RD_CNT : GAP.
//  RD_CNT: same read sequence at UPINHSKCNT_ADDR; rdata latched to hskcnt; rresp!=OKAY -> ERR(2); else FIN.
//  FIN: done=1 one cycle, busy=0, -> IDLE. hskcnt holds until next FIN.
//  ERR: error=1, busy=0, -> IDLE in 1 cycle; error/err_code hold.
//  Timeout: counter runs in GAP/RD_END only; at TIMEOUT -> ERR(3) only when no read outstanding
//   (checked in GAP); outstanding read always completes first — no abandoned AXI transaction.
//  start while busy: ignored, no effect. start and rst same cycle: rst wins.
//  rst mid-transaction: immediate return to reset state; valids drop (bench must reset slave too).
//  Max one outstanding transaction; AR never issued while AW/W/B pending.
// CONFIGURATION
//  CRF_MASTER_IRQ_WAIT_EN defined: GAP/RD_END replaced by waiting for interrupt_updone high
//   (level, sampled), then -> RD_CNT; timeout counts the wait. UPEND never read.
//  Not defined: interrupt_updone ignored; polling as above.
// STRUCTURE
//  Shared package crf_pkg: AXI resp localparams (OKAY=2'b00, SLVERR=2'b10), CRF register address
//   localparams, err_code enum, FSM state typedef.
//  Sub-module lite_rd_chan (AR/R single-read engine: req, addr -> rdata, rresp, ack) reused for both reads.
// TESTING
//  1 Slave zero-wait, UPEND=1 on 3rd poll, POLL_GAP=4 -> one write (addr 0,data 1), 3 UPEND reads, done pulse, hskcnt=slave value (e.g. 'h21C00).
//  2 awready delayed 5 cycles, wready immediate -> wvalid drops after 1 cycle, awvalid held 5; no duplicate write.
//  3 bresp=SLVERR -> error=1, err_code=1, no AR issued, busy=0 next cycle.
//  4 UPEND never set, TIMEOUT=200 -> err_code=3, last read completed, no valids high after ERR.
//  5 start pulsed during busy and rst asserted mid-RD_END -> start ignored; after rst all outputs 0, new start runs clean.
//  6 CRF_MASTER_IRQ_WAIT_EN, interrupt_updone raised at cycle 50 -> no UPEND read, single UPINHSKCNT read, done.

Source files
------------

// File: rtl/crf_pkg.sv
// Shared definitions for the CRF lite master and its read engine.
// Contents: AXI response codes, default CRF register byte addresses,
// the error-code encoding reported to the host, and the master FSM state type.
package crf_pkg;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    localparam logic [31:0] CRF_UPSTART_ADDR    = 32'h0000_0000;
    localparam logic [31:0] CRF_UPEND_ADDR      = 32'h0000_0004;
    localparam logic [31:0] CRF_UPINHSKCNT_ADDR = 32'h0000_0008;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_BRESP   = 2'd1,
        ERR_RRESP   = 2'd2,
        ERR_TIMEOUT = 2'd3
    } err_code_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_WR_RESP,
        S_GAP,
        S_RD_END,
        S_RD_CNT,
        S_FIN,
        S_ERR
    } state_e;

endpackage

// File: rtl/lite_rd_chan.sv
// Single-beat AXI4-Lite read engine (AR + R channels).
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   req_i, addr_i       1-cycle request to read addr_i (caller guarantees idle)
//   m_axi_ar*_o/_i      AR channel; arvalid held until arready
//   m_axi_r*_i/_o       R channel; rready raised only after AR is accepted
//   ack_o               high in the R handshake cycle; rdata_o/rresp_o valid then
module lite_rd_chan
    import crf_pkg::*;
#(
    parameter int unsigned AXI_DATA_WIDTH = 32,
    parameter int unsigned AXI_ADDR_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req_i,
    input  logic [AXI_ADDR_WIDTH-1:0] addr_i,
    output logic                      m_axi_arvalid_o,
    output logic [AXI_ADDR_WIDTH-1:0] m_axi_araddr_o,
    output logic [2:0]                m_axi_arprot_o,
    input  logic                      m_axi_arready_i,
    input  logic                      m_axi_rvalid_i,
    input  logic [AXI_DATA_WIDTH-1:0] m_axi_rdata_i,
    input  logic [1:0]                m_axi_rresp_i,
    output logic                      m_axi_rready_o,
    output logic                      ack_o,
    output logic [AXI_DATA_WIDTH-1:0] rdata_o,
    output logic [1:0]                rresp_o
);

    logic                      arvalid_q, arvalid_d;
    logic [AXI_ADDR_WIDTH-1:0] araddr_q, araddr_d;
    logic                      rready_q, rready_d;

    always_comb begin
        arvalid_d = arvalid_q;
        araddr_d  = araddr_q;
        rready_d  = rready_q;
        if (arvalid_q && m_axi_arready_i) begin
            arvalid_d = 1'b0;
            rready_d  = 1'b1;
        end
        if (rready_q && m_axi_rvalid_i) begin
            rready_d = 1'b0;
        end
        // A new request may arrive in the same cycle the previous R beat completes.
        if (req_i) begin
            arvalid_d = 1'b1;
            araddr_d  = addr_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            arvalid_q <= 1'b0;
            araddr_q  <= '0;
            rready_q  <= 1'b0;
        end else begin
            arvalid_q <= arvalid_d;
            araddr_q  <= araddr_d;
            rready_q  <= rready_d;
        end
    end

    assign m_axi_arvalid_o = arvalid_q;
    assign m_axi_araddr_o  = araddr_q;
    assign m_axi_arprot_o  = '0;
    assign m_axi_rready_o  = rready_q;
    assign ack_o           = rready_q && m_axi_rvalid_i;
    assign rdata_o         = m_axi_rdata_i;
    assign rresp_o         = m_axi_rresp_i;

endmodule

// File: rtl/crf_lite_master.sv
// AXI4-Lite master running one CRF upscale job per host start pulse:
// write UPSTART=1, wait for UPEND bit0, read UPINHSKCNT, report to host.
// Build option: CRF_MASTER_IRQ_WAIT_EN replaces UPEND polling with waiting
// for interrupt_updone (level); otherwise interrupt_updone is ignored.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   start                       1-cycle job start, accepted only when idle
//   busy, done, error, err_code host status (done 1-cycle, error sticky)
//   hskcnt                      UPINHSKCNT value, valid from done
//   m_axi_aw*/w*/b*/ar*/r*      AXI4-Lite master interface
//   interrupt_updone            CRF done interrupt
module crf_lite_master
    import crf_pkg::*;
#(
    parameter int unsigned                AXI_DATA_WIDTH  = 32,
    parameter int unsigned                AXI_ADDR_WIDTH  = 32,
    parameter logic [AXI_ADDR_WIDTH-1:0]  UPSTART_ADDR    = AXI_ADDR_WIDTH'(CRF_UPSTART_ADDR),
    parameter logic [AXI_ADDR_WIDTH-1:0]  UPEND_ADDR      = AXI_ADDR_WIDTH'(CRF_UPEND_ADDR),
    parameter logic [AXI_ADDR_WIDTH-1:0]  UPINHSKCNT_ADDR = AXI_ADDR_WIDTH'(CRF_UPINHSKCNT_ADDR),
    parameter int unsigned                POLL_GAP        = 16,
    parameter int unsigned                TIMEOUT         = 2**20
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    output logic                        busy,
    output logic                        done,
    output logic                        error,
    output logic [1:0]                  err_code,
    output logic [AXI_DATA_WIDTH-1:0]   hskcnt,
    output logic                        m_axi_awvalid,
    output logic [AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic [2:0]                  m_axi_awprot,
    input  logic                        m_axi_awready,
    output logic                        m_axi_wvalid,
    output logic [AXI_DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
    input  logic                        m_axi_wready,
    input  logic                        m_axi_bvalid,
    input  logic [1:0]                  m_axi_bresp,
    output logic                        m_axi_bready,
    output logic                        m_axi_arvalid,
    output logic [AXI_ADDR_WIDTH-1:0]   m_axi_araddr,
    output logic [2:0]                  m_axi_arprot,
    input  logic                        m_axi_arready,
    input  logic                        m_axi_rvalid,
    input  logic [AXI_DATA_WIDTH-1:0]   m_axi_rdata,
    input  logic [1:0]                  m_axi_rresp,
    output logic                        m_axi_rready,
    input  logic                        interrupt_updone
);

    state_e                      state_q;
    logic                        busy_q, done_q, error_q;
    err_code_e                   err_code_q;
    logic [AXI_DATA_WIDTH-1:0]   hskcnt_q;
    logic                        awvalid_q, wvalid_q, bready_q;
    logic [AXI_ADDR_WIDTH-1:0]   awaddr_q;
    logic [AXI_DATA_WIDTH-1:0]   wdata_q;
    logic [AXI_DATA_WIDTH/8-1:0] wstrb_q;
    logic [31:0]                 tmo_q;
`ifndef CRF_MASTER_IRQ_WAIT_EN
    logic [31:0]                 gap_cnt_q;
    logic                        unused_irq;
    assign unused_irq = interrupt_updone;
`endif

    logic                        rd_req, rd_ack, tmo_hit;
    logic [AXI_ADDR_WIDTH-1:0]   rd_addr;
    logic [AXI_DATA_WIDTH-1:0]   rd_rdata;
    logic [1:0]                  rd_rresp;

    // Read requests are decoded from the current state so that arvalid rises
    // on the same edge the FSM enters the read state.
    always_comb begin
        rd_req  = 1'b0;
        rd_addr = UPINHSKCNT_ADDR;
        tmo_hit = (TIMEOUT != 0) && (tmo_q >= 32'(TIMEOUT));
        case (state_q)
`ifdef CRF_MASTER_IRQ_WAIT_EN
            S_GAP:    rd_req = !tmo_hit && interrupt_updone;
`else
            S_GAP: begin
                rd_req  = !tmo_hit && (gap_cnt_q == 32'(POLL_GAP - 1));
                rd_addr = UPEND_ADDR;
            end
            S_RD_END: rd_req = rd_ack && (rd_rresp == AXI_RESP_OKAY) && rd_rdata[0];
`endif
            default:  rd_req = 1'b0;
        endcase
    end

    lite_rd_chan #(
        .AXI_DATA_WIDTH (AXI_DATA_WIDTH),
        .AXI_ADDR_WIDTH (AXI_ADDR_WIDTH)
    ) u_rd_chan (
        .clk             (clk),
        .rst             (rst),
        .req_i           (rd_req),
        .addr_i          (rd_addr),
        .m_axi_arvalid_o (m_axi_arvalid),
        .m_axi_araddr_o  (m_axi_araddr),
        .m_axi_arprot_o  (m_axi_arprot),
        .m_axi_arready_i (m_axi_arready),
        .m_axi_rvalid_i  (m_axi_rvalid),
        .m_axi_rdata_i   (m_axi_rdata),
        .m_axi_rresp_i   (m_axi_rresp),
        .m_axi_rready_o  (m_axi_rready),
        .ack_o           (rd_ack),
        .rdata_o         (rd_rdata),
        .rresp_o         (rd_rresp)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            err_code_q <= ERR_NONE;
            hskcnt_q   <= '0;
            awvalid_q  <= 1'b0;
            wvalid_q   <= 1'b0;
            bready_q   <= 1'b0;
            awaddr_q   <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            tmo_q      <= '0;
`ifndef CRF_MASTER_IRQ_WAIT_EN
            gap_cnt_q  <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            if (state_q == S_GAP || state_q == S_RD_END) begin
                tmo_q <= tmo_q + 32'd1;
            end
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q    <= S_WR;
                        busy_q     <= 1'b1;
                        error_q    <= 1'b0;
                        err_code_q <= ERR_NONE;
                        tmo_q      <= '0;
                        awvalid_q  <= 1'b1;
                        wvalid_q   <= 1'b1;
                        awaddr_q   <= UPSTART_ADDR;
                        wdata_q    <= AXI_DATA_WIDTH'(1);
                        wstrb_q    <= '1;
                    end
                end
                S_WR: begin
                    if (awvalid_q && m_axi_awready) awvalid_q <= 1'b0;
                    if (wvalid_q && m_axi_wready)   wvalid_q  <= 1'b0;
                    // A channel counts as accepted if it handshakes now or already did.
                    if ((!awvalid_q || m_axi_awready) && (!wvalid_q || m_axi_wready)) begin
                        state_q  <= S_WR_RESP;
                        bready_q <= 1'b1;
                    end
                end
                S_WR_RESP: begin
                    if (m_axi_bvalid && bready_q) begin
                        bready_q <= 1'b0;
                        if (m_axi_bresp == AXI_RESP_OKAY) begin
                            state_q   <= S_GAP;
`ifndef CRF_MASTER_IRQ_WAIT_EN
                            gap_cnt_q <= '0;
`endif
                        end else begin
                            state_q    <= S_ERR;
                            busy_q     <= 1'b0;
                            error_q    <= 1'b1;
                            err_code_q <= ERR_BRESP;
                        end
                    end
                end
                // Timeout is only honoured here, where no read is in flight.
                S_GAP: begin
                    if (tmo_hit) begin
                        state_q    <= S_ERR;
                        busy_q     <= 1'b0;
                        error_q    <= 1'b1;
                        err_code_q <= ERR_TIMEOUT;
                    end else if (rd_req) begin
`ifdef CRF_MASTER_IRQ_WAIT_EN
                        state_q <= S_RD_CNT;
`else
                        state_q <= S_RD_END;
`endif
                    end else begin
`ifndef CRF_MASTER_IRQ_WAIT_EN
                        gap_cnt_q <= gap_cnt_q + 32'd1;
`endif
                    end
                end
`ifndef CRF_MASTER_IRQ_WAIT_EN
                S_RD_END: begin
                    if (rd_ack) begin
                        if (rd_rresp != AXI_RESP_OKAY) begin
                            state_q    <= S_ERR;
                            busy_q     <= 1'b0;
                            error_q    <= 1'b1;
                            err_code_q <= ERR_RRESP;
                        end else if (rd_rdata[0]) begin
                            state_q <= S_RD_CNT;
                        end else begin
                            state_q   <= S_GAP;
                            gap_cnt_q <= '0;
                        end
                    end
                end
`endif
                S_RD_CNT: begin
                    if (rd_ack) begin
                        if (rd_rresp != AXI_RESP_OKAY) begin
                            state_q    <= S_ERR;
                            busy_q     <= 1'b0;
                            error_q    <= 1'b1;
                            err_code_q <= ERR_RRESP;
                        end else begin
                            state_q  <= S_FIN;
                            hskcnt_q <= rd_rdata;
                            busy_q   <= 1'b0;
                            done_q   <= 1'b1;
                        end
                    end
                end
                S_FIN:   state_q <= S_IDLE;
                S_ERR:   state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign error         = error_q;
    assign err_code      = err_code_q;
    assign hskcnt        = hskcnt_q;
    assign m_axi_awvalid = awvalid_q;
    assign m_axi_awaddr  = awaddr_q;
    assign m_axi_awprot  = '0;
    assign m_axi_wvalid  = wvalid_q;
    assign m_axi_wdata   = wdata_q;
    assign m_axi_wstrb   = wstrb_q;
    assign m_axi_bready  = bready_q;

endmodule

// File: tb/tb_crf_lite_master.sv
// Self-checking bench for crf_lite_master with a behavioural AXI4-Lite slave.
// Build with or without CRF_MASTER_IRQ_WAIT_EN; the vector table adapts.
module tb_crf_lite_master;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        irq = 1'b0;
    logic        busy, done, error;
    logic [1:0]  err_code;
    logic [31:0] hskcnt;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [3:0]  wstrb;
    logic [2:0]  awprot, arprot;
    logic [1:0]  bresp, rresp;

    always #5 clk = ~clk;

    crf_lite_master #(
        .AXI_DATA_WIDTH (32),
        .AXI_ADDR_WIDTH (32),
        .POLL_GAP       (4),
        .TIMEOUT        (200)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .busy             (busy),
        .done             (done),
        .error            (error),
        .err_code         (err_code),
        .hskcnt           (hskcnt),
        .m_axi_awvalid    (awvalid),
        .m_axi_awaddr     (awaddr),
        .m_axi_awprot     (awprot),
        .m_axi_awready    (awready),
        .m_axi_wvalid     (wvalid),
        .m_axi_wdata      (wdata),
        .m_axi_wstrb      (wstrb),
        .m_axi_wready     (wready),
        .m_axi_bvalid     (bvalid),
        .m_axi_bresp      (bresp),
        .m_axi_bready     (bready),
        .m_axi_arvalid    (arvalid),
        .m_axi_araddr     (araddr),
        .m_axi_arprot     (arprot),
        .m_axi_arready    (arready),
        .m_axi_rvalid     (rvalid),
        .m_axi_rdata      (rdata),
        .m_axi_rresp      (rresp),
        .m_axi_rready     (rready),
        .interrupt_updone (irq)
    );

    // ---------------- behavioural slave + monitor ----------------
    int unsigned cfg_aw_delay = 0, cfg_w_delay = 0, cfg_upend_poll = 0;
    logic [1:0]  cfg_bresp = 2'b00, cfg_rresp = 2'b00;
    logic [31:0] cfg_cnt = 32'h0;
    logic        clr_stats = 1'b0;

    int unsigned aw_cnt, w_cnt;
    logic        aw_got, w_got, aw_wait, w_wait, ar_wait;
    int unsigned n_aw, n_ur, n_cr, aw_hi, w_hi, n_done, n_viol;

    assign awready = awvalid && (aw_cnt >= cfg_aw_delay);
    assign wready  = wvalid && (w_cnt >= cfg_w_delay);
    assign arready = arvalid;

    always @(posedge clk) begin
        if (rst) begin
            aw_cnt <= 0; w_cnt <= 0; aw_got <= 1'b0; w_got <= 1'b0;
            aw_wait <= 1'b0; w_wait <= 1'b0; ar_wait <= 1'b0;
            bvalid <= 1'b0; bresp <= 2'b00; rvalid <= 1'b0; rresp <= 2'b00; rdata <= 32'h0;
            n_aw <= 0; n_ur <= 0; n_cr <= 0; aw_hi <= 0; w_hi <= 0; n_done <= 0;
        end else begin
            if (clr_stats) begin
                n_aw <= 0; n_ur <= 0; n_cr <= 0; aw_hi <= 0; w_hi <= 0; n_done <= 0;
            end else begin
                if (awvalid) aw_hi <= aw_hi + 1;
                if (wvalid)  w_hi  <= w_hi + 1;
                if (done)    n_done <= n_done + 1;
                if (awvalid && awready) n_aw <= n_aw + 1;
                if (arvalid && arready && araddr == 32'h4) n_ur <= n_ur + 1;
                if (arvalid && arready && araddr == 32'h8) n_cr <= n_cr + 1;
            end
            // valids must never drop before their handshake
            if ((aw_wait && !awvalid) || (w_wait && !wvalid) || (ar_wait && !arvalid)) n_viol <= n_viol + 1;
            aw_wait <= awvalid && !awready;
            w_wait  <= wvalid && !wready;
            ar_wait <= arvalid && !arready;
            aw_cnt  <= (awvalid && !awready) ? aw_cnt + 1 : 0;
            w_cnt   <= (wvalid && !wready) ? w_cnt + 1 : 0;
            if (awvalid && awready) begin
                aw_got <= 1'b1;
                if (awaddr != 32'h0 || awprot != 3'b000) n_viol <= n_viol + 1;
            end
            if (wvalid && wready) begin
                w_got <= 1'b1;
                if (wdata != 32'h1 || wstrb != 4'hF) n_viol <= n_viol + 1;
            end
            if (aw_got && w_got) begin
                aw_got <= 1'b0; w_got <= 1'b0;
                bvalid <= 1'b1; bresp <= cfg_bresp;
            end
            if (bvalid && bready) bvalid <= 1'b0;
            // no read may be issued while any write phase is pending
            if (arvalid && (awvalid || wvalid || aw_got || w_got || bvalid)) n_viol <= n_viol + 1;
            if (arvalid && arready) begin
                rvalid <= 1'b1;
                rresp  <= cfg_rresp;
                if (araddr == 32'h4)
                    rdata <= (cfg_upend_poll != 0 && n_ur + 1 >= cfg_upend_poll) ? 32'h1 : 32'h0;
                else if (araddr == 32'h8)
                    rdata <= cfg_cnt;
                else begin
                    rdata  <= 32'h0;
                    n_viol <= n_viol + 1;
                end
                if (arprot != 3'b000) n_viol <= n_viol + 1;
            end
            if (rvalid && rready) rvalid <= 1'b0;
        end
    end

    // ---------------- checking ----------------
    int unsigned n_tests = 0, n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        int unsigned aw_delay;
        int unsigned w_delay;
        logic [1:0]  bresp;
        logic [1:0]  rresp;
        int unsigned upend_poll;
        int unsigned irq_at;
        logic [31:0] cnt;
        logic [1:0]  exp_err;
        logic [31:0] exp_hsk;
        int unsigned exp_ur;
        int unsigned exp_cr;
        int unsigned exp_awhi;
        int unsigned exp_whi;
    } vec_t;

    function automatic vec_t mk(input int unsigned awd, input int unsigned wd, input logic [1:0] br,
                                input logic [1:0] rr, input int unsigned up, input int unsigned ia,
                                input logic [31:0] cnt, input logic [1:0] ee, input logic [31:0] eh,
                                input int unsigned eur, input int unsigned ecr,
                                input int unsigned eaw, input int unsigned ew);
        vec_t v;
        v.aw_delay = awd; v.w_delay = wd; v.bresp = br; v.rresp = rr; v.upend_poll = up;
        v.irq_at = ia; v.cnt = cnt; v.exp_err = ee; v.exp_hsk = eh; v.exp_ur = eur;
        v.exp_cr = ecr; v.exp_awhi = eaw; v.exp_whi = ew;
        return v;
    endfunction

    task automatic run_job(input vec_t v, input string tag);
        logic fin;
        cfg_aw_delay = v.aw_delay; cfg_w_delay = v.w_delay; cfg_bresp = v.bresp;
        cfg_rresp = v.rresp; cfg_upend_poll = v.upend_poll; cfg_cnt = v.cnt;
        clr_stats = 1'b1;
        @(negedge clk);
        clr_stats = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, " busy_after_start"}, {31'b0, busy}, 32'd1);
        fin = 1'b0;
        for (int unsigned cyc = 1; cyc < 3000; cyc++) begin
            if (done || error) begin
                fin = 1'b1;
                break;
            end
            if (v.irq_at != 0 && cyc >= v.irq_at) irq = 1'b1;
            @(negedge clk);
        end
        check({tag, " finished"}, {31'b0, fin}, 32'd1);
        check({tag, " done"}, {31'b0, done}, (v.exp_err == 2'd0) ? 32'd1 : 32'd0);
        check({tag, " error"}, {31'b0, error}, (v.exp_err != 2'd0) ? 32'd1 : 32'd0);
        check({tag, " err_code"}, {30'b0, err_code}, {30'b0, v.exp_err});
        check({tag, " busy_end"}, {31'b0, busy}, 32'd0);
        check({tag, " hskcnt"}, hskcnt, v.exp_hsk);
        check({tag, " n_aw"}, n_aw, 32'd1);
        check({tag, " n_upend_rd"}, n_ur, v.exp_ur);
        check({tag, " n_cnt_rd"}, n_cr, v.exp_cr);
        check({tag, " awvalid_cycles"}, aw_hi, v.exp_awhi);
        check({tag, " wvalid_cycles"}, w_hi, v.exp_whi);
        check({tag, " bus_idle"}, {27'b0, awvalid, wvalid, bready, arvalid, rready}, 32'd0);
        @(negedge clk);
        irq = 1'b0;
        check({tag, " done_dropped"}, {31'b0, done}, 32'd0);
        check({tag, " done_pulses"}, n_done, (v.exp_err == 2'd0) ? 32'd1 : 32'd0);
        check({tag, " error_held"}, {30'b0, err_code}, {30'b0, v.exp_err});
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, " status"}, {28'b0, busy, done, error, 1'b0}, 32'd0);
        check({tag, " err_code"}, {30'b0, err_code}, 32'd0);
        check({tag, " hskcnt"}, hskcnt, 32'd0);
        check({tag, " valids"}, {27'b0, awvalid, wvalid, bready, arvalid, rready}, 32'd0);
        check({tag, " awaddr"}, awaddr, 32'd0);
        check({tag, " araddr"}, araddr, 32'd0);
        check({tag, " wdata"}, wdata, 32'd0);
        check({tag, " wstrb"}, {28'b0, wstrb}, 32'd0);
    endtask

    vec_t vecs[$];
    logic seen;

    initial begin
        n_viol = 0;
`ifdef CRF_MASTER_IRQ_WAIT_EN
        //              awd wd bresp  rresp  up irq cnt            err  hsk           ur cr aw w
        vecs.push_back(mk(0, 0, 2'b00, 2'b00, 0, 50, 32'h0000_1234, 2'd0, 32'h0000_1234, 0, 1, 1, 1));
        vecs.push_back(mk(0, 0, 2'b00, 2'b00, 0, 0,  32'h0000_5555, 2'd3, 32'h0000_1234, 0, 0, 1, 1));
        vecs.push_back(mk(0, 0, 2'b10, 2'b00, 0, 5,  32'h0000_6666, 2'd1, 32'h0000_1234, 0, 0, 1, 1));
        vecs.push_back(mk(0, 0, 2'b00, 2'b10, 0, 10, 32'h0000_7777, 2'd2, 32'h0000_1234, 0, 1, 1, 1));
`else
        vecs.push_back(mk(0, 0, 2'b00, 2'b00, 3, 0, 32'h0002_1C00, 2'd0, 32'h0002_1C00, 3,  1, 1, 1));
        vecs.push_back(mk(5, 0, 2'b00, 2'b00, 1, 0, 32'h0000_0005, 2'd0, 32'h0000_0005, 1,  1, 6, 1));
        vecs.push_back(mk(0, 0, 2'b10, 2'b00, 1, 0, 32'h0000_0077, 2'd1, 32'h0000_0005, 0,  0, 1, 1));
        // 6-cycle poll period (4 GAP + 2 RD_END); timeout hits in the 34th GAP before its read
        vecs.push_back(mk(0, 0, 2'b00, 2'b00, 0, 0, 32'h0000_0099, 2'd3, 32'h0000_0005, 33, 0, 1, 1));
        vecs.push_back(mk(0, 0, 2'b00, 2'b10, 1, 0, 32'h0000_0088, 2'd2, 32'h0000_0005, 1,  0, 1, 1));
        vecs.push_back(mk(0, 3, 2'b00, 2'b00, 2, 0, 32'hDEAD_BEEF, 2'd0, 32'hDEAD_BEEF, 2,  1, 1, 4));
`endif

        repeat (3) @(negedge clk);
        check_reset_state("reset");
        rst = 1'b0;
        @(negedge clk);
        check_reset_state("idle");

        foreach (vecs[i]) run_job(vecs[i], $sformatf("vec%0d", i));

        // start while busy is ignored; reset in the middle of a read
        cfg_aw_delay = 0; cfg_w_delay = 0; cfg_bresp = 2'b00; cfg_rresp = 2'b00;
        cfg_upend_poll = 0; cfg_cnt = 32'h42;
        clr_stats = 1'b1;
        @(negedge clk);
        clr_stats = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_start_busy", {31'b0, busy}, 32'd1);
        check("busy_start_err", {31'b0, error}, 32'd0);
        seen = 1'b0;
`ifdef CRF_MASTER_IRQ_WAIT_EN
        repeat (20) @(negedge clk);
        seen = busy;
`else
        for (int unsigned c = 0; c < 100; c++) begin
            if (arvalid) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
`endif
        check("mid_job_reached", {31'b0, seen}, 32'd1);
        check("no_dup_write", n_aw, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_state("midrst");
        repeat (3) @(negedge clk);
        check("midrst_quiet", {27'b0, awvalid, wvalid, bready, arvalid, rready}, 32'd0);

        // rst and start in the same cycle: reset wins
        start = 1'b1; rst = 1'b1;
        @(negedge clk);
        start = 1'b0; rst = 1'b0;
        check("rst_start_busy", {31'b0, busy}, 32'd0);
        repeat (2) @(negedge clk);
        check("rst_start_valids", {30'b0, awvalid, wvalid}, 32'd0);

        // clean job after reset
`ifdef CRF_MASTER_IRQ_WAIT_EN
        run_job(mk(0, 0, 2'b00, 2'b00, 0, 30, 32'h0000_0ABC, 2'd0, 32'h0000_0ABC, 0, 1, 1, 1), "post_rst");
`else
        run_job(mk(0, 0, 2'b00, 2'b00, 3, 0, 32'h0002_1C00, 2'd0, 32'h0002_1C00, 3, 1, 1, 1), "post_rst");
`endif

        check("protocol_violations", n_viol, 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
